// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit: ID-stage forwarding selects, branch-compare forward bits and a stall
// request covering load-use hazards and in-flight multi-cycle writes.  Rev 1.0
`default_nettype none

module fwd_scoreboard_unit #(
   parameter int ADDR_W  = 5,
   parameter int NUM_SRC = 2,
   parameter int LAT_W   = 3
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic [NUM_SRC*ADDR_W-1:0]   Id_Src_Addr,
   input  logic [NUM_SRC-1:0]          Id_Src_Valid,
   input  logic [ADDR_W-1:0]           Id_Ex_Rd,
   input  logic                        Id_Ex_RegWrite,
   input  logic                        Id_Ex_MemRead,
   input  logic [ADDR_W-1:0]           Ex_Mem_Rd,
   input  logic                        Ex_Mem_RegWrite,
   input  logic                        Issue_Valid,
   input  logic [ADDR_W-1:0]           Issue_Rd,
   input  logic [LAT_W-1:0]            Issue_Lat,
   input  logic                        Flush,
   output logic [2*NUM_SRC-1:0]        Fwd_Sel,
   output logic [NUM_SRC-1:0]          Id_Fwd,
   output logic                        Stall,
   output logic [ADDR_W:0]             Busy_Count
);

   localparam int c_NREG = 2**ADDR_W;

   logic [LAT_W-1:0]   r_cnt     [c_NREG];
   logic [LAT_W-1:0]   w_cnt_nxt [c_NREG];
   logic [ADDR_W:0]    w_busy_nxt;
   logic [ADDR_W:0]    r_busy;
   logic [2*NUM_SRC-1:0] r_fwd_sel;

   logic               w_issue;
   logic [LAT_W-1:0]   w_lat;

   logic [ADDR_W-1:0]  w_addr    [NUM_SRC];
   logic [NUM_SRC-1:0] w_act;
   logic [NUM_SRC-1:0] w_lu_hit;
   logic [NUM_SRC-1:0] w_sb_hit;
   logic [NUM_SRC-1:0] w_ex_hit;
   logic [NUM_SRC-1:0] w_mem_hit;
   logic [1:0]         w_fwd_nxt [NUM_SRC];

   assign w_issue = Issue_Valid && (Issue_Rd != '0) && !Flush;
   // A zero latency still needs one cycle to reach write-back.
   assign w_lat   = (Issue_Lat == '0) ? LAT_W'(1) : Issue_Lat;

   always_comb begin
      w_busy_nxt = '0;
      for (int r = 0; r < c_NREG; r++) begin
         if (r == 0)
            w_cnt_nxt[r] = '0;
         else if (w_issue && (Issue_Rd == ADDR_W'(r)))
            w_cnt_nxt[r] = w_lat;
         else if (r_cnt[r] != '0)
            w_cnt_nxt[r] = r_cnt[r] - LAT_W'(1);
         else
            w_cnt_nxt[r] = '0;
         if (w_cnt_nxt[r] != '0)
            w_busy_nxt = w_busy_nxt + (ADDR_W+1)'(1);
      end
   end

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         assign w_addr[i]    = Id_Src_Addr[i*ADDR_W +: ADDR_W];
         assign w_act[i]     = Id_Src_Valid[i] && (w_addr[i] != '0);
         assign w_lu_hit[i]  = Id_Ex_MemRead && Id_Ex_RegWrite && (Id_Ex_Rd == w_addr[i]);
         // A count of 1 lands in MEM/WB next cycle and is covered by forwarding.
         assign w_sb_hit[i]  = r_cnt[w_addr[i]] > LAT_W'(1);
         assign w_ex_hit[i]  = Id_Ex_RegWrite && (Id_Ex_Rd != '0) &&
                               (Id_Ex_Rd == w_addr[i]) && Id_Src_Valid[i];
         assign w_mem_hit[i] = Ex_Mem_RegWrite && (Ex_Mem_Rd != '0) &&
                               (Ex_Mem_Rd == w_addr[i]) && Id_Src_Valid[i];
         assign w_fwd_nxt[i] = (Stall || Flush) ? 2'b00 :
                               w_ex_hit[i]      ? 2'b10 :
                               w_mem_hit[i]     ? 2'b01 : 2'b00;
      end
   endgenerate

   assign Stall      = !Flush && (|(w_act & (w_lu_hit | w_sb_hit)));
   assign Id_Fwd     = w_mem_hit;
   assign Fwd_Sel    = r_fwd_sel;
   assign Busy_Count = r_busy;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int r = 0; r < c_NREG; r++)
            r_cnt[r] <= '0;
         r_fwd_sel <= '0;
         r_busy    <= '0;
      end else begin
         for (int r = 0; r < c_NREG; r++)
            r_cnt[r] <= w_cnt_nxt[r];
         for (int i = 0; i < NUM_SRC; i++)
            r_fwd_sel[2*i +: 2] <= w_fwd_nxt[i];
         r_busy <= w_busy_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard_unit.sv
// tb_fwd_scoreboard_unit: scoreboard bench with a ready-time reference model of fwd_scoreboard_unit.
`default_nettype none

module tb_fwd_scoreboard_unit;

   localparam int AW = 5;
   localparam int NS = 2;
   localparam int LW = 3;

   logic            Clk = 1'b0;
   logic            Rst = 1'b0;
   logic [NS*AW-1:0] Id_Src_Addr = '0;
   logic [NS-1:0]   Id_Src_Valid = '0;
   logic [AW-1:0]   Id_Ex_Rd = '0;
   logic            Id_Ex_RegWrite = 1'b0;
   logic            Id_Ex_MemRead = 1'b0;
   logic [AW-1:0]   Ex_Mem_Rd = '0;
   logic            Ex_Mem_RegWrite = 1'b0;
   logic            Issue_Valid = 1'b0;
   logic [AW-1:0]   Issue_Rd = '0;
   logic [LW-1:0]   Issue_Lat = '0;
   logic            Flush = 1'b0;
   logic [2*NS-1:0] Fwd_Sel;
   logic [NS-1:0]   Id_Fwd;
   logic            Stall;
   logic [AW:0]     Busy_Count;

   always #5 Clk = ~Clk;

   fwd_scoreboard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .LAT_W(LW)) dut (
      .Clk(Clk), .Rst(Rst), .Id_Src_Addr(Id_Src_Addr), .Id_Src_Valid(Id_Src_Valid),
      .Id_Ex_Rd(Id_Ex_Rd), .Id_Ex_RegWrite(Id_Ex_RegWrite), .Id_Ex_MemRead(Id_Ex_MemRead),
      .Ex_Mem_Rd(Ex_Mem_Rd), .Ex_Mem_RegWrite(Ex_Mem_RegWrite), .Issue_Valid(Issue_Valid),
      .Issue_Rd(Issue_Rd), .Issue_Lat(Issue_Lat), .Flush(Flush), .Fwd_Sel(Fwd_Sel),
      .Id_Fwd(Id_Fwd), .Stall(Stall), .Busy_Count(Busy_Count)
   );

   typedef struct {
      logic            stall;
      logic [NS-1:0]   idfwd;
      logic [2*NS-1:0] fsel;
      logic [AW:0]     busy;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // staged stimulus for the next cycle
   logic            s_rst, s_exrw, s_exmr, s_mrw, s_iv, s_fl;
   logic [NS*AW-1:0] s_addr;
   logic [NS-1:0]   s_sv;
   logic [AW-1:0]   s_exrd, s_mrd, s_ird;
   logic [LW-1:0]   s_ilat;

   // reference model: absolute cycle at which each register's result has retired
   int              m_t = 0;
   int              m_ready [2**AW];
   logic [2*NS-1:0] m_fsel = '0;
   int              m_busy = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("Stall",      8'(Stall),      8'(e.stall));
         chk("Id_Fwd",     8'(Id_Fwd),     8'(e.idfwd));
         chk("Fwd_Sel",    8'(Fwd_Sel),    8'(e.fsel));
         chk("Busy_Count", 8'(Busy_Count), 8'(e.busy));
      end
   end

   task automatic idle();
      s_rst = 1'b1; s_addr = '0; s_sv = '0; s_exrd = '0; s_exrw = 1'b0; s_exmr = 1'b0;
      s_mrd = '0; s_mrw = 1'b0; s_iv = 1'b0; s_ird = '0; s_ilat = '0; s_fl = 1'b0;
   endtask

   task automatic set_src(input int i, input int a);
      s_addr[i*AW +: AW] = AW'(a);
      s_sv[i] = 1'b1;
   endtask

   task automatic drive();
      exp_t            e;
      logic            stall;
      logic [NS-1:0]   idfwd;
      logic [2*NS-1:0] fnext;
      int              a, lat;
      @(posedge Clk);
      #1;
      Rst = s_rst; Id_Src_Addr = s_addr; Id_Src_Valid = s_sv; Id_Ex_Rd = s_exrd;
      Id_Ex_RegWrite = s_exrw; Id_Ex_MemRead = s_exmr; Ex_Mem_Rd = s_mrd;
      Ex_Mem_RegWrite = s_mrw; Issue_Valid = s_iv; Issue_Rd = s_ird; Issue_Lat = s_ilat;
      Flush = s_fl;

      stall = 1'b0;
      idfwd = '0;
      for (int i = 0; i < NS; i++) begin
         a = int'(s_addr[i*AW +: AW]);
         if (s_sv[i] && a != 0 &&
             ((s_exmr && s_exrw && int'(s_exrd) == a) || (m_ready[a] - m_t > 1)))
            stall = 1'b1;
         idfwd[i] = s_mrw && s_mrd != 0 && int'(s_mrd) == a && s_sv[i];
      end
      if (s_fl) stall = 1'b0;

      fnext = '0;
      for (int i = 0; i < NS; i++) begin
         a = int'(s_addr[i*AW +: AW]);
         if (!stall && !s_fl) begin
            if (s_exrw && s_exrd != 0 && int'(s_exrd) == a && s_sv[i])
               fnext[2*i +: 2] = 2'b10;
            else if (idfwd[i])
               fnext[2*i +: 2] = 2'b01;
         end
      end

      e.stall = stall; e.idfwd = idfwd; e.fsel = m_fsel; e.busy = (AW+1)'(m_busy);
      q.push_back(e);

      m_t++;
      if (!s_rst) begin
         for (int r = 0; r < 2**AW; r++) m_ready[r] = 0;
         m_fsel = '0;
         m_busy = 0;
      end else begin
         if (s_iv && s_ird != 0 && !s_fl) begin
            lat = (s_ilat == 0) ? 1 : int'(s_ilat);
            m_ready[s_ird] = m_t + lat;
         end
         m_fsel = fnext;
         m_busy = 0;
         for (int r = 1; r < 2**AW; r++)
            if (m_ready[r] > m_t) m_busy++;
      end
   endtask

   task automatic run_idle(input int n);
      for (int k = 0; k < n; k++) begin
         idle();
         drive();
      end
   endtask

   initial begin
      for (int r = 0; r < 2**AW; r++) m_ready[r] = 0;

      // reset dominates a concurrent issue
      for (int k = 0; k < 2; k++) begin
         idle(); s_rst = 1'b0; s_iv = 1'b1; s_ird = 5; s_ilat = 3;
         drive();
      end
      run_idle(2);

      // EX over MEM priority, MEM-only, and r0
      idle(); set_src(0, 3); s_exrd = 3; s_exrw = 1; s_mrd = 3; s_mrw = 1; drive();
      idle(); set_src(0, 3); s_exrd = 3; s_exrw = 0; s_mrd = 3; s_mrw = 1; drive();
      idle(); set_src(0, 0); s_exrd = 0; s_exrw = 1; s_mrd = 0; s_mrw = 1; drive();
      run_idle(1);

      // load-use, then the same under flush
      idle(); set_src(1, 7); s_exmr = 1; s_exrw = 1; s_exrd = 7; drive();
      idle(); set_src(1, 7); s_exmr = 1; s_exrw = 1; s_exrd = 7; s_fl = 1; drive();
      run_idle(1);

      // scoreboard countdown
      idle(); s_iv = 1; s_ird = 9; s_ilat = 4; drive();
      for (int k = 0; k < 6; k++) begin idle(); set_src(0, 9); drive(); end

      // WAW reload with latency 2, then with latency 0
      for (int v = 0; v < 2; v++) begin
         idle(); s_iv = 1; s_ird = 9; s_ilat = 4; drive();
         idle(); set_src(0, 9); drive();
         idle(); set_src(0, 9); s_iv = 1; s_ird = 9; s_ilat = (v == 0) ? 3'd2 : 3'd0; drive();
         for (int k = 0; k < 4; k++) begin idle(); set_src(0, 9); drive(); end
      end

      // flushed issue is dropped; a pending entry keeps counting
      idle(); s_iv = 1; s_ird = 4; s_fl = 1; drive();
      idle(); s_iv = 1; s_ird = 12; s_ilat = 5; drive();
      idle(); s_iv = 1; s_ird = 4; s_ilat = 6; s_fl = 1; set_src(0, 12); drive();
      for (int k = 0; k < 6; k++) begin idle(); set_src(0, 12); set_src(1, 4); drive(); end

      // randomized traffic with a narrow address range to provoke hits
      for (int k = 0; k < 3000; k++) begin
         idle();
         s_rst = ($urandom_range(0, 99) != 0);
         for (int i = 0; i < NS; i++) begin
            s_addr[i*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            s_sv[i] = ($urandom_range(0, 3) != 0);
         end
         s_exrd = AW'($urandom_range(0, 7)); s_exrw = ($urandom_range(0, 9) < 7);
         s_exmr = ($urandom_range(0, 9) < 3);
         s_mrd  = AW'($urandom_range(0, 7)); s_mrw = ($urandom_range(0, 9) < 7);
         s_iv   = ($urandom_range(0, 9) < 3);
         s_ird  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         s_ilat = LW'($urandom);
         s_fl   = ($urandom_range(0, 9) == 0);
         drive();
      end
      run_idle(10);

      @(negedge Clk);
      @(negedge Clk);
      chk("queue_drained", 8'(q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
Parametrised successor to the pipeline forwarding unit. It is evaluated at ID and generates registered EX-stage operand forwarding selects for NUM_SRC sources, ID-stage (branch-compare) forward bits, and a stall request. The stall request covers load-use hazards and a per-register scoreboard of in-flight multi-cycle writes (MUL/DIV). It sits beside the hazard unit in each core's pipeline.

Parameters:
ADDR_W, 5, register address width; register file has 2**ADDR_W entries, register 0 never tracked.
NUM_SRC, 2, source operands per instruction.
LAT_W, 3, width of multi-cycle latency field; max latency 2**LAT_W-1.

Ports:
Clk  in  1  core clock, all state on rising edge.
Rst  in  1  synchronous reset, active-low.
Id_Src_Addr  in  NUM_SRC*ADDR_W  ID-stage source addresses; source i at bits [i*ADDR_W +: ADDR_W].
Id_Src_Valid  in  NUM_SRC  source i is actually read.
Id_Ex_Rd  in  ADDR_W  destination of instruction in EX.
Id_Ex_RegWrite  in  1  EX instruction writes Rd.
Id_Ex_MemRead  in  1  EX instruction is a load.
Ex_Mem_Rd  in  ADDR_W  destination in MEM.
Ex_Mem_RegWrite  in  1  MEM instruction writes Rd.
Issue_Valid  in  1  multi-cycle op leaving EX this cycle.
Issue_Rd  in  ADDR_W  its destination.
Issue_Lat  in  LAT_W  cycles until its result is written back.
Flush  in  1  squash ID/EX (branch taken).
Fwd_Sel  out  2*NUM_SRC  registered EX-stage mux select per source; 2'b10 = EX/MEM, 2'b01 = MEM/WB, 2'b00 = register file.
Id_Fwd  out  NUM_SRC  combinational; ID source i takes EX/MEM result.
Stall  out  1  combinational; hold PC and IF/ID, insert bubble.
Busy_Count  out  ADDR_W+1  registered count of pending scoreboard entries.

Behaviour:
- Reset (Rst=0 at edge): all counters 0, Fwd_Sel=0, Busy_Count=0. Combinational outputs follow state, so Stall=0 when inputs are idle. Reset dominates Issue and Flush.
- Scoreboard: one LAT_W counter per register 1..2**ADDR_W-1. Pending means counter != 0.
- Every cycle, each nonzero counter decrements by 1, saturating at 0.
- Issue: if Issue_Valid && Issue_Rd!=0 && !Flush, the counter for Issue_Rd is loaded with Issue_Lat; Issue_Lat=0 is treated as 1. The loaded value is not decremented in the same cycle.
- Re-issue to an already pending register overwrites its counter (newest wins, WAW).
- Issue_Rd=0 and issue during Flush are ignored. Flush does not clear existing counters.
- Source i is "active" when Id_Src_Valid[i] && addr_i!=0.
- Stall = OR over active sources of:
  - (Id_Ex_MemRead && Id_Ex_RegWrite && Id_Ex_Rd==addr_i), or
  - counter[addr_i] > 1. A counter of 1 means the result is in MEM/WB next cycle, so normal forwarding covers it.
- Stall is forced to 0 when Flush=1.
- Fwd_Sel next-state per source i, updated at each edge:
  - If Stall or Flush: 2'b00, because a bubble enters EX.
  - Else if Id_Ex_RegWrite && Id_Ex_Rd!=0 && Id_Ex_Rd==addr_i && Id_Src_Valid[i]: 2'b10.
  - Else if Ex_Mem_RegWrite && Ex_Mem_Rd!=0 && Ex_Mem_Rd==addr_i && Id_Src_Valid[i]: 2'b01.
  - Else 2'b00.
  - Priority: the younger writer (EX) wins over MEM.
  - Latency: 1 cycle; Fwd_Sel is valid while the instruction is in EX.
- Id_Fwd[i] = Ex_Mem_RegWrite && Ex_Mem_Rd!=0 && Ex_Mem_Rd==addr_i && Id_Src_Valid[i].
- Busy_Count next = number of counters that will be nonzero after this edge's decrement/load. Maximum value 2**ADDR_W-1.

Test Plan:
- Reset: hold Rst=0 for 2 cycles with Issue_Valid=1, Issue_Rd=5 -> after release, Busy_Count=0, Fwd_Sel=0, Stall=0.
- EX priority: Id_Src_Addr src0=3, Id_Ex_Rd=3 with RegWrite, Ex_Mem_Rd=3 with RegWrite -> next cycle Fwd_Sel[1:0]=2'b10. Repeat with Id_Ex_RegWrite=0 -> 2'b01. Repeat with addr=0 -> 2'b00.
- Load-use: Id_Ex_MemRead=1, Id_Ex_Rd=7, src1=7 -> Stall=1 same cycle and Fwd_Sel=0 next cycle. With Flush=1 in the same cycle -> Stall=0.
- Scoreboard: issue Rd=9, Lat=4, then read src0=9 each cycle -> Stall=1 for 3 cycles, then 0 when the counter reaches 1; Busy_Count sequence 1,1,1,1,0.
- WAW/overlap: issue Rd=9 Lat=4; two cycles later issue Rd=9 Lat=2 and Rd=9 Lat=0 in separate runs -> counter reloads to 2 and to 1 respectively; Busy_Count stays 1 until expiry.
- Flush: Issue_Valid=1, Issue_Rd=4, Flush=1 -> no entry created (Busy_Count=0). An entry already pending keeps counting down.
